// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU op codes,
// opcodes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUop/funct fields to an ALU control code; purely combinational.
// bad_funct_o flags a funct3 outside the supported ALU subset, independent of ALUop.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic       bad_funct_o
);

  always_comb begin
    bad_funct_o = 1'b0;
    case (funct3_i)
      3'b000, 3'b010, 3'b110, 3'b111: bad_funct_o = 1'b0;
      default:                        bad_funct_o = 1'b1;
    endcase
  end

  always_comb begin
    alu_control_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type has a sub form; for I-type bit 30 belongs to the immediate.
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM: Moore outputs decoded from state, sticky illegal flag.
// Write enables are held low while reset is asserted, whatever the current state.
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter logic ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUcontrol,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [1:0] aluop;
  logic       bad_funct;
  logic       pc_write_st, ir_write_st, reg_write_st, mem_write_st;

  alu_decoder u_alu_dec (
    .aluop_i      (aluop),
    .funct3_i     (funct3),
    .op5_i        (op[5]),
    .funct7b5_i   (funct7b5),
    .alu_control_o(ALUcontrol),
    .bad_funct_o  (bad_funct)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // A bad funct3 is caught while leaving DECODE so the flag is visible in the execute state.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R: begin
            state_d = S_EXECR;
            if (bad_funct) illegal_d = 1'b1;
          end
          OP_I: begin
            state_d = S_EXECI;
            if (bad_funct) illegal_d = 1'b1;
          end
          OP_BEQ:  state_d = S_BEQ;
          OP_JAL:  state_d = S_JAL;
          default: begin
            state_d   = ILLEGAL_HALT ? S_HALT : S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB,
      S_MEMWRITE,
      S_ALUWB,
      S_BEQ:      state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_st  = 1'b0;
    ir_write_st  = 1'b0;
    reg_write_st = 1'b0;
    mem_write_st = 1'b0;
    AdrSrc       = 1'b0;
    ResultSrc    = RES_ALUOUT;
    ALUSrcA      = SRCA_PC;
    ALUSrcB      = SRCB_RS2;
    aluop        = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write_st = 1'b1;
        pc_write_st = 1'b1;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc    = RES_DATA;
        reg_write_st = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc       = 1'b1;
        mem_write_st = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_st = 1'b1;
      S_BEQ: begin
        ALUSrcA     = SRCA_RS1;
        aluop       = ALUOP_SUB;
        pc_write_st = zero;
      end
      S_JAL: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        pc_write_st = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  assign PCWrite  = pc_write_st  & ~reset;
  assign IRWrite  = ir_write_st  & ~reset;
  assign RegWrite = reg_write_st & ~reset;
  assign MemWrite = mem_write_st & ~reset;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class state by state and
// compares the full output vector against hand-written per-state expectations.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUcontrol;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mc_control_unit #(.ILLEGAL_HALT(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .zero      (zero),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .ResultSrc (ResultSrc),
    .ALUcontrol(ALUcontrol),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .RegWrite  (RegWrite),
    .illegal   (illegal)
  );

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUcontrol, ALUSrcA, ALUSrcB, RegWrite}
  function automatic logic [13:0] sig(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] res,
                                      input logic [2:0] alu, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic rw);
    return {pcw, adr, mw, irw, res, alu, sa, sb, rw};
  endfunction

  function automatic logic [13:0] s_execr(input logic [2:0] alu);
    return sig(0, 0, 0, 0, 2'b00, alu, 2'b10, 2'b00, 0);
  endfunction
  function automatic logic [13:0] s_execi(input logic [2:0] alu);
    return sig(0, 0, 0, 0, 2'b00, alu, 2'b10, 2'b01, 0);
  endfunction
  function automatic logic [13:0] s_beq(input logic z);
    return sig(z, 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b00, 0);
  endfunction

  logic [13:0] S_FETCH_X, S_FETCH_RST, S_DECODE_X, S_MEMADR_X, S_MEMREAD_X, S_MEMWB_X;
  logic [13:0] S_MEMWR_X, S_ALUWB_X, S_JAL_X, S_ZERO_X, S_MEMWB_RST;

  task automatic chk(input string tag, input logic [13:0] exp_sig,
                     input logic [1:0] exp_imm, input logic exp_ill);
    logic [16:0] obs, exp_v;
    #1;
    obs   = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUcontrol, ALUSrcA, ALUSrcB,
             RegWrite, ImmSrc, illegal};
    exp_v = {exp_sig, exp_imm, exp_ill};
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  // Executes one R/I ALU instruction from FETCH back to FETCH (4 cycles).
  task automatic run_alu(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [2:0] exp_alu, input logic exp_ill);
    set_instr(o, f3, f7);
    step(); chk({tag, "_decode"}, S_DECODE_X, 2'b00, 1'b0);
    step(); chk({tag, "_exec"}, (o == 7'b0110011) ? s_execr(exp_alu) : s_execi(exp_alu),
                2'b00, exp_ill);
    step(); chk({tag, "_aluwb"}, S_ALUWB_X, 2'b00, exp_ill);
    step(); chk({tag, "_fetch"}, S_FETCH_X, 2'b00, exp_ill);
  endtask

  initial begin
    S_FETCH_X   = sig(1, 0, 0, 1, 2'b10, 3'b000, 2'b00, 2'b10, 0);
    S_FETCH_RST = sig(0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 2'b10, 0);
    S_DECODE_X  = sig(0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b01, 0);
    S_MEMADR_X  = sig(0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 0);
    S_MEMREAD_X = sig(0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 0);
    S_MEMWB_X   = sig(0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 1);
    S_MEMWB_RST = sig(0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 0);
    S_MEMWR_X   = sig(0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 0);
    S_ALUWB_X   = sig(0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 1);
    S_JAL_X     = sig(1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 0);
    S_ZERO_X    = 14'd0;

    reset = 1'b1;
    zero  = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);
    step(); step();
    chk("reset_fetch_gated", S_FETCH_RST, 2'b00, 1'b0);
    reset = 1'b0;
    chk("fetch_after_reset", S_FETCH_X, 2'b00, 1'b0);

    // lw: five cycles, RegWrite only in MEMWB
    step(); chk("lw_decode", S_DECODE_X, 2'b00, 1'b0);
    step(); chk("lw_memadr", S_MEMADR_X, 2'b00, 1'b0);
    step(); chk("lw_memread", S_MEMREAD_X, 2'b00, 1'b0);
    step(); chk("lw_memwb", S_MEMWB_X, 2'b00, 1'b0);
    step(); chk("lw_fetch", S_FETCH_X, 2'b00, 1'b0);

    // sw: MemWrite for exactly one cycle, S-type immediate
    set_instr(7'b0100011, 3'b010, 1'b0);
    step(); chk("sw_decode", S_DECODE_X, 2'b01, 1'b0);
    step(); chk("sw_memadr", S_MEMADR_X, 2'b01, 1'b0);
    step(); chk("sw_memwrite", S_MEMWR_X, 2'b01, 1'b0);
    step(); chk("sw_fetch", S_FETCH_X, 2'b01, 1'b0);

    run_alu("r_sub", 7'b0110011, 3'b000, 1'b1, 3'b001, 1'b0);
    run_alu("i_addi", 7'b0010011, 3'b000, 1'b1, 3'b000, 1'b0);
    run_alu("r_slt", 7'b0110011, 3'b010, 1'b0, 3'b101, 1'b0);
    run_alu("i_ori", 7'b0010011, 3'b110, 1'b0, 3'b011, 1'b0);
    run_alu("r_and", 7'b0110011, 3'b111, 1'b0, 3'b010, 1'b0);

    // beq taken, then PCWrite tracking zero in the same cycle
    set_instr(7'b1100011, 3'b000, 1'b0);
    zero = 1'b1;
    step(); chk("beq_t_decode", S_DECODE_X, 2'b10, 1'b0);
    step(); chk("beq_t_branch", s_beq(1'b1), 2'b10, 1'b0);
    zero = 1'b0;
    chk("beq_zero_follow", s_beq(1'b0), 2'b10, 1'b0);
    step(); chk("beq_t_fetch", S_FETCH_X, 2'b10, 1'b0);
    step(); chk("beq_nt_decode", S_DECODE_X, 2'b10, 1'b0);
    step(); chk("beq_nt_branch", s_beq(1'b0), 2'b10, 1'b0);
    step(); chk("beq_nt_fetch", S_FETCH_X, 2'b10, 1'b0);

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0);
    step(); chk("jal_decode", S_DECODE_X, 2'b11, 1'b0);
    step(); chk("jal_jal", S_JAL_X, 2'b11, 1'b0);
    step(); chk("jal_aluwb", S_ALUWB_X, 2'b11, 1'b0);
    step(); chk("jal_fetch", S_FETCH_X, 2'b11, 1'b0);

    // reset held two cycles starting mid-EXECR
    set_instr(7'b0110011, 3'b000, 1'b0);
    step(); step();
    chk("execr_before_rst", s_execr(3'b000), 2'b00, 1'b0);
    reset = 1'b1;
    chk("execr_in_rst", s_execr(3'b000), 2'b00, 1'b0);
    step(); chk("rst_cycle1", S_FETCH_RST, 2'b00, 1'b0);
    step(); chk("rst_cycle2", S_FETCH_RST, 2'b00, 1'b0);
    reset = 1'b0;
    chk("rst_release", S_FETCH_X, 2'b00, 1'b0);

    // reset arriving in MEMWB suppresses the register write
    set_instr(7'b0000011, 3'b010, 1'b0);
    step(); step(); step(); step();
    chk("lw2_memwb", S_MEMWB_X, 2'b00, 1'b0);
    reset = 1'b1;
    chk("memwb_rst_gated", S_MEMWB_RST, 2'b00, 1'b0);
    step(); reset = 1'b0;
    chk("memwb_rst_fetch", S_FETCH_X, 2'b00, 1'b0);

    // unsupported funct3 on R-type: flagged on entry to EXECR, ALU falls back to add
    run_alu("r_badf3", 7'b0110011, 3'b001, 1'b0, 3'b000, 1'b1);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("badf3_cleared", S_FETCH_X, 2'b00, 1'b0);

    // illegal opcode: HALT with no enables until reset
    set_instr(7'b1111111, 3'b000, 1'b0);
    step(); chk("ill_decode", S_DECODE_X, 2'b00, 1'b0);
    step(); chk("ill_halt1", S_ZERO_X, 2'b00, 1'b1);
    step(); chk("ill_halt2", S_ZERO_X, 2'b00, 1'b1);
    step(); chk("ill_halt3", S_ZERO_X, 2'b00, 1'b1);
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("ill_after_reset", S_FETCH_X, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
